frame_update_sched: RTL and testbench
=====================================

FRAME_UPDATE_SCHED -- requirements
Module: frame_update_sched

Interface
REQ-001 The block SHALL have parameter CORDW, default 10, meaning coordinate width in bits.
REQ-002 The block SHALL have parameter H_RES, default 640, meaning the active width used for the x clamp.
REQ-003 The block SHALL have parameter V_RES, default 480, meaning the active height used for the y clamp.
REQ-004 The block SHALL have parameter MAX_PER_FRAME, default 4, meaning the most commands applied per frame.
REQ-005 i_clk input 1: sole clock (pixel clock domain); all logic SHALL be clocked on its rising edge.
REQ-006 rst input 1: reset, synchronous and active-high.
REQ-007 valid_data input 1: one-cycle strobe qualifying uart_buf.
REQ-008 uart_buf input 32: command word {id[31:30], rsvd[29:26], x[25:16], rsvd[15:10], y[9:0]}.
REQ-009 n_vsync input 1: active-low vertical sync from the display timing block.
REQ-010 o_pos0, o_pos1, o_pos2 output 2*CORDW each: live {x,y} of object 0 (left paddle), object 1 (right paddle) and object 2 (ball).
REQ-011 o_overflow output 1: sticky flag indicating a command was dropped.
REQ-012 o_applying output 1: high while state is DRAIN.
REQ-013 o_frame_cnt output 16: count of vsync starts seen, wraps 0xFFFF->0.

Function
REQ-014 Push: valid_data=1 with FIFO not full SHALL write uart_buf into a 4-entry FIFO at that edge.
REQ-015 Full: valid_data=1 with FIFO full and no pop in the same cycle SHALL drop the word and set o_overflow.
REQ-016 Push and pop in the same cycle at full SHALL both succeed; o_overflow SHALL be unchanged.
REQ-017 Frame start SHALL be n_vsync sampled 1 then 0 on consecutive edges, registered one cycle.
REQ-018 Each frame start SHALL increment o_frame_cnt.
REQ-019 FSM states: IDLE and DRAIN.
REQ-020 IDLE->DRAIN SHALL occur on frame start when the FIFO is non-empty; the per-frame budget counter SHALL load 0.
REQ-021 In DRAIN, one entry SHALL be popped and applied per cycle, and the budget SHALL increment.
REQ-022 DRAIN->IDLE SHALL occur in the cycle after the pop that empties the FIFO or brings the budget to MAX_PER_FRAME.
REQ-023 A frame start seen while in DRAIN SHALL be ignored for FSM purposes; o_frame_cnt SHALL still increment.
REQ-024 A word pushed during DRAIN SHALL be poppable no earlier than the next cycle, and only if budget remains.
REQ-025 Apply latency: the addressed o_posN SHALL update at the edge that pops the entry.
REQ-026 id 0/1/2: x SHALL clamp to min(x, H_RES-1) and y to min(y, V_RES-1); reserved bits SHALL be ignored.
REQ-027 id 3: all positions SHALL return to package defaults and o_overflow SHALL clear.
REQ-028 If id 3 pops in the same cycle as an overflow event, o_overflow SHALL end set.
REQ-029 Outputs SHALL change only in DRAIN (or on reset), so positions are stable through active video.

Reset
REQ-030 On rst=1 the block SHALL empty the FIFO, set FSM=IDLE, budget=0, o_frame_cnt=0, o_overflow=0 and o_applying=0.
REQ-031 On rst=1 positions SHALL reset to o_pos0={16,224}, o_pos1={616,224}, o_pos2={316,236}.
REQ-032 rst SHALL dominate all other inputs, including mid-DRAIN; pending FIFO entries SHALL be discarded.
REQ-033 The n_vsync edge history SHALL reset to 1 so that no false frame start follows reset.

Structure
REQ-034 Package frame_sched_pkg SHALL hold: the cmd_t packed-struct typedef, the obj_id_e enum (PAD_L, PAD_R, BALL, CLR), the default positions, and the state enum.
REQ-035 Sub-module cmd_fifo (parameterised width and depth 4, registered pointers, full/empty flags) SHALL hold the queue.
REQ-036 The top SHALL contain edge detect, FSM, budget counter, decode/clamp, and the position registers.

Verification
REQ-037 Scenario: reset, then idle vsync pulses -> positions at defaults, o_frame_cnt counts, o_applying stays 0.
REQ-038 Scenario: push id1 x=700 y=500, then a frame start -> o_pos1={639,479} exactly one cycle after DRAIN entry; o_applying high for 1 cycle.
REQ-039 Scenario: 5 pushes before vsync -> 5th dropped, o_overflow=1, 4 applied in 4 consecutive cycles.
REQ-040 Scenario: MAX_PER_FRAME=2 with 4 queued -> 2 applied on frame N, 2 on frame N+1.
REQ-041 Scenario: rst asserted mid-DRAIN with 2 entries left -> next edge shows defaults, FIFO empty, IDLE; the next frame applies nothing.
REQ-042 Scenario: queue id0 {100,50}, then id3 -> after the frame, o_pos0 is the default and o_overflow=0.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// Shared types and constants for the frame-synchronised object update scheduler.
// Command word layout, object ids, FSM states and power-on object positions.
package frame_sched_pkg;

    localparam int unsigned CMD_W      = 32;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        PAD_L = 2'd0,
        PAD_R = 2'd1,
        BALL  = 2'd2,
        CLR   = 2'd3
    } obj_id_e;

    typedef struct packed {
        obj_id_e    id;
        logic [3:0] rsvd_hi;
        logic [9:0] x;
        logic [5:0] rsvd_lo;
        logic [9:0] y;
    } cmd_t;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam int unsigned PAD_L_X = 16;
    localparam int unsigned PAD_L_Y = 224;
    localparam int unsigned PAD_R_X = 616;
    localparam int unsigned PAD_R_Y = 224;
    localparam int unsigned BALL_X  = 316;
    localparam int unsigned BALL_Y  = 236;

    function automatic int unsigned clamp(input int unsigned v, input int unsigned lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small show-ahead command queue with wrap-bit pointers; a pop frees a slot for a
// simultaneous push even when full.
module cmd_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign count_o = wptr_q - rptr_q;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem_d[i] = mem_q[i];
        end
        if (do_push) begin
            mem_d[wptr_q[AW-1:0]] = wdata_i;
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/frame_update_sched.sv
// Queues object-position commands from the UART and applies them only at frame start,
// at most MAX_PER_FRAME per frame, so positions never change during active video.
module frame_update_sched
    import frame_sched_pkg::*;
#(
    parameter int unsigned CORDW         = 10,
    parameter int unsigned H_RES         = 640,
    parameter int unsigned V_RES         = 480,
    parameter int unsigned MAX_PER_FRAME = 4
) (
    input  logic               i_clk,
    input  logic               rst,
    input  logic               valid_data,
    input  logic [31:0]        uart_buf,
    input  logic               n_vsync,
    output logic [2*CORDW-1:0] o_pos0,
    output logic [2*CORDW-1:0] o_pos1,
    output logic [2*CORDW-1:0] o_pos2,
    output logic               o_overflow,
    output logic               o_applying,
    output logic [15:0]        o_frame_cnt
);

    localparam int unsigned BW = $clog2(MAX_PER_FRAME + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [2*CORDW-1:0] POS0_DEF = {CORDW'(PAD_L_X), CORDW'(PAD_L_Y)};
    localparam logic [2*CORDW-1:0] POS1_DEF = {CORDW'(PAD_R_X), CORDW'(PAD_R_Y)};
    localparam logic [2*CORDW-1:0] POS2_DEF = {CORDW'(BALL_X), CORDW'(BALL_Y)};

    state_e            state_q, state_d;
    logic [BW-1:0]     budget_q, budget_d;
    logic              vs_q, vs_d;
    logic              fs_q, fs_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              ovf_q, ovf_d;
    logic [2*CORDW-1:0] pos0_q, pos0_d;
    logic [2*CORDW-1:0] pos1_q, pos1_d;
    logic [2*CORDW-1:0] pos2_q, pos2_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [CMD_W-1:0]  fifo_rdata;
    logic              pop;
    logic              push;
    logic              ovf_evt;
    logic              last_entry;
    cmd_t              cmd;
    logic [CORDW-1:0]  cx;
    logic [CORDW-1:0]  cy;
    logic [2*CORDW-1:0] cmd_pos;

    assign pop        = (state_q == DRAIN) && !fifo_empty && (budget_q < BW'(MAX_PER_FRAME));
    assign push       = valid_data && (!fifo_full || pop);
    assign ovf_evt    = valid_data && fifo_full && !pop;
    // The pop leaves the queue empty unless a new word lands in the same cycle.
    assign last_entry = (fifo_count == CW'(1)) && !push;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk_i   (i_clk),
        .rst_i   (rst),
        .push_i  (push),
        .wdata_i (uart_buf),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign cmd     = cmd_t'(fifo_rdata);
    assign cx      = CORDW'(clamp(32'(cmd.x), H_RES - 1));
    assign cy      = CORDW'(clamp(32'(cmd.y), V_RES - 1));
    assign cmd_pos = {cx, cy};

    always_comb begin
        vs_d        = n_vsync;
        fs_d        = vs_q && !n_vsync;
        frame_cnt_d = fs_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
        state_d     = state_q;
        budget_d    = budget_q;
        ovf_d       = ovf_q;
        pos0_d      = pos0_q;
        pos1_d      = pos1_q;
        pos2_d      = pos2_q;

        unique case (state_q)
            IDLE: begin
                if (fs_q && !fifo_empty) begin
                    state_d  = DRAIN;
                    budget_d = '0;
                end
            end
            DRAIN: begin
                if (pop) begin
                    budget_d = budget_q + 1'b1;
                    if (last_entry || budget_q == BW'(MAX_PER_FRAME - 1)) begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            unique case (cmd.id)
                PAD_L: pos0_d = cmd_pos;
                PAD_R: pos1_d = cmd_pos;
                BALL:  pos2_d = cmd_pos;
                CLR: begin
                    pos0_d = POS0_DEF;
                    pos1_d = POS1_DEF;
                    pos2_d = POS2_DEF;
                    ovf_d  = 1'b0;
                end
                default: ;
            endcase
        end
        // A drop in the same cycle wins over a clear.
        if (ovf_evt) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            budget_q    <= '0;
            vs_q        <= 1'b1;
            fs_q        <= 1'b0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
            pos0_q      <= POS0_DEF;
            pos1_q      <= POS1_DEF;
            pos2_q      <= POS2_DEF;
        end else begin
            state_q     <= state_d;
            budget_q    <= budget_d;
            vs_q        <= vs_d;
            fs_q        <= fs_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
            pos0_q      <= pos0_d;
            pos1_q      <= pos1_d;
            pos2_q      <= pos2_d;
        end
    end

    assign o_pos0      = pos0_q;
    assign o_pos1      = pos1_q;
    assign o_pos2      = pos2_q;
    assign o_overflow  = ovf_q;
    assign o_applying  = (state_q == DRAIN);
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_update_sched.sv
// Directed bench for frame_update_sched: a default instance plus a MAX_PER_FRAME=2 instance
// sharing the same stimulus.
module tb_frame_update_sched;

    logic        i_clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_data = 1'b0;
    logic [31:0] uart_buf = '0;
    logic        n_vsync = 1'b1;

    logic [19:0] pos0, pos1, pos2;
    logic        ovf, applying;
    logic [15:0] fcnt;
    logic [19:0] b_pos0, b_pos1, b_pos2;
    logic        b_ovf, b_applying;
    logic [15:0] b_fcnt;

    int n_pass = 0;
    int n_total = 0;

    always #5 i_clk = ~i_clk;

    frame_update_sched dut (
        .i_clk       (i_clk),
        .rst         (rst),
        .valid_data  (valid_data),
        .uart_buf    (uart_buf),
        .n_vsync     (n_vsync),
        .o_pos0      (pos0),
        .o_pos1      (pos1),
        .o_pos2      (pos2),
        .o_overflow  (ovf),
        .o_applying  (applying),
        .o_frame_cnt (fcnt)
    );

    frame_update_sched #(
        .MAX_PER_FRAME (2)
    ) dut2 (
        .i_clk       (i_clk),
        .rst         (rst),
        .valid_data  (valid_data),
        .uart_buf    (uart_buf),
        .n_vsync     (n_vsync),
        .o_pos0      (b_pos0),
        .o_pos1      (b_pos1),
        .o_pos2      (b_pos2),
        .o_overflow  (b_ovf),
        .o_applying  (b_applying),
        .o_frame_cnt (b_fcnt)
    );

    localparam logic [19:0] D0 = {10'd16, 10'd224};
    localparam logic [19:0] D1 = {10'd616, 10'd224};
    localparam logic [19:0] D2 = {10'd316, 10'd236};

    function automatic logic [19:0] xy(input int x, input int y);
        return {10'(x), 10'(y)};
    endfunction

    function automatic logic [31:0] cw(input int id, input int x, input int y, input int rsvd);
        return {2'(id), 4'(rsvd), 10'(x), 6'(rsvd), 10'(y)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        valid_data = 1'b1;
        uart_buf   = w;
        step();
        valid_data = 1'b0;
    endtask

    // Ends one cycle after the registered frame start has been consumed.
    task automatic vsync_pulse();
        n_vsync = 1'b0;
        step();
        n_vsync = 1'b1;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_pos0", pos0, D0);
        chk("rst_pos1", pos1, D1);
        chk("rst_pos2", pos2, D2);
        chk("rst_ovf", ovf, 0);
        chk("rst_applying", applying, 0);
        chk("rst_fcnt", fcnt, 0);

        // Idle frames
        vsync_pulse();
        chk("idle_fcnt1", fcnt, 1);
        chk("idle_applying1", applying, 0);
        step();
        vsync_pulse();
        chk("idle_fcnt2", fcnt, 2);
        chk("idle_applying2", applying, 0);
        chk("idle_pos2", pos2, D2);

        // Clamp, reserved bits ignored, one-cycle apply
        push(cw(1, 700, 500, 15));
        vsync_pulse();
        chk("clamp_applying", applying, 1);
        chk("clamp_pos1_before", pos1, D1);
        chk("clamp_fcnt", fcnt, 3);
        step();
        chk("clamp_pos1", pos1, xy(639, 479));
        chk("clamp_applying_done", applying, 0);

        // Five pushes: fifth dropped, four applied back to back
        push(cw(0, 10, 20, 0));
        push(cw(1, 30, 40, 0));
        push(cw(2, 50, 60, 0));
        push(cw(0, 70, 80, 0));
        chk("ovf_before5", ovf, 0);
        push(cw(2, 1, 2, 0));
        chk("ovf_after5", ovf, 1);
        vsync_pulse();
        chk("burst_applying0", applying, 1);
        step();
        chk("burst_pos0a", pos0, xy(10, 20));
        step();
        chk("burst_pos1", pos1, xy(30, 40));
        step();
        chk("burst_pos2", pos2, xy(50, 60));
        chk("burst_applying3", applying, 1);
        step();
        chk("burst_pos0b", pos0, xy(70, 80));
        chk("burst_applying_done", applying, 0);
        vsync_pulse();
        chk("burst_empty_applying", applying, 0);
        chk("burst_dropped", pos2, xy(50, 60));

        // Clear command restores defaults and clears overflow
        push(cw(0, 100, 50, 0));
        push(cw(3, 0, 0, 0));
        vsync_pulse();
        step();
        chk("clr_pos0_first", pos0, xy(100, 50));
        chk("clr_ovf_held", ovf, 1);
        step();
        chk("clr_pos0", pos0, D0);
        chk("clr_pos1", pos1, D1);
        chk("clr_pos2", pos2, D2);
        chk("clr_ovf", ovf, 0);

        // Push while full and popping: accepted, no overflow, deferred to next frame
        do_reset();
        push(cw(0, 1, 1, 0));
        push(cw(1, 2, 2, 0));
        push(cw(2, 3, 3, 0));
        push(cw(0, 4, 4, 0));
        vsync_pulse();
        push(cw(1, 5, 5, 0));
        chk("pp_pos0", pos0, xy(1, 1));
        chk("pp_ovf", ovf, 0);
        step();
        step();
        step();
        chk("pp_pos0_last", pos0, xy(4, 4));
        chk("pp_budget_stop", applying, 0);
        chk("pp_pos1_kept", pos1, xy(2, 2));
        vsync_pulse();
        step();
        chk("pp_pos1_next", pos1, xy(5, 5));

        // Budget of two per frame on the second instance
        do_reset();
        push(cw(0, 11, 11, 0));
        push(cw(1, 12, 12, 0));
        push(cw(2, 13, 13, 0));
        push(cw(0, 14, 14, 0));
        vsync_pulse();
        chk("b2_applying", b_applying, 1);
        step();
        chk("b2_pos0a", b_pos0, xy(11, 11));
        step();
        chk("b2_pos1", b_pos1, xy(12, 12));
        chk("b2_stop", b_applying, 0);
        step();
        chk("b2_pos2_wait", b_pos2, D2);
        vsync_pulse();
        step();
        chk("b2_pos2", b_pos2, xy(13, 13));
        step();
        chk("b2_pos0b", b_pos0, xy(14, 14));
        chk("b2_done", b_applying, 0);

        // Reset mid-drain discards pending entries
        do_reset();
        push(cw(0, 21, 21, 0));
        push(cw(1, 22, 22, 0));
        push(cw(2, 23, 23, 0));
        push(cw(0, 24, 24, 0));
        vsync_pulse();
        step();
        step();
        chk("mid_pos1", pos1, xy(22, 22));
        chk("mid_applying", applying, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_pos0", pos0, D0);
        chk("mid_rst_pos1", pos1, D1);
        chk("mid_rst_applying", applying, 0);
        chk("mid_rst_fcnt", fcnt, 0);
        rst = 1'b0;
        vsync_pulse();
        chk("mid_next_applying", applying, 0);
        chk("mid_next_fcnt", fcnt, 1);
        step();
        chk("mid_next_pos2", pos2, D2);
        chk("mid_next_pos0", pos0, D0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
